// File: rtl/osnt_sume_endianess_swapper_if.sv
// AXI4-Stream bus bundle used by the endianess swapper on both its slave and master sides.
interface osnt_sume_endianess_swapper_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/osnt_sume_endianess_swapper.sv
// AXI4-Stream byte-order converter: per-packet latched swap mode, output register plus one skid register.
// Optional statistics counters are built when OSNT_SWAPPER_STATS_EN is defined.
module osnt_sume_endianess_swapper #(
  parameter int C_AXIS_TDATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEFAULT_MODE     = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [1:0]                    CFG_SWAP_MODE,
  osnt_sume_endianess_swapper_if.slave  s_axis,
  osnt_sume_endianess_swapper_if.master m_axis,
  output logic [1:0]                    STAT_MODE_ACTIVE,
  output logic                          DBG_FSM_STATE
`ifdef OSNT_SWAPPER_STATS_EN
  ,
  input  logic                          STAT_CLR,
  output logic [31:0]                   STAT_PKT_CNT,
  output logic [31:0]                   STAT_BEAT_CNT
`endif
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int U  = C_AXIS_TUSER_WIDTH;
  localparam int NB = W / 8;
  localparam logic [1:0] DEF_MODE = 2'(C_DEFAULT_MODE);

  // Handshake: a beat moves on a bus when tvalid & tready are both high at a rising ACLK edge;
  // tvalid never waits on tready, and payload is held while tvalid=1 and tready=0.

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic           s_ready_q, s_ready_d;

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [NB-1:0]  out_keep_q, out_keep_d;
  logic [U-1:0]   out_user_q, out_user_d;
  logic           out_last_q, out_last_d;

  logic           skid_valid_q, skid_valid_d;
  logic [W-1:0]   skid_data_q, skid_data_d;
  logic [NB-1:0]  skid_keep_q, skid_keep_d;
  logic [U-1:0]   skid_user_q, skid_user_d;
  logic           skid_last_q, skid_last_d;

  logic           accept;
  logic           out_free;
  logic [1:0]     beat_mode;
  logic [W-1:0]   sw_data;
  logic [NB-1:0]  sw_keep;

  // Source byte index for output byte i under a given swap granularity.
  function automatic int src_byte(input int i, input logic [1:0] mode);
    case (mode)
      2'd1:    src_byte = NB - 1 - i;
      2'd2:    src_byte = i ^ 3;
      2'd3:    src_byte = i ^ 7;
      default: src_byte = i;
    endcase
  endfunction

  always_comb begin
    beat_mode = (state_q == ST_IDLE) ? CFG_SWAP_MODE : mode_q;
    sw_data   = '0;
    sw_keep   = '0;
    for (int i = 0; i < NB; i++) begin
      sw_data[8*i +: 8] = s_axis.tdata[8*src_byte(i, beat_mode) +: 8];
      sw_keep[i]        = s_axis.tkeep[src_byte(i, beat_mode)];
    end
  end

  always_comb begin
    accept   = s_axis.tvalid & s_ready_q;
    out_free = ~out_valid_q | m_axis.tready;

    state_d      = state_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_user_d   = out_user_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_user_d  = skid_user_q;
    skid_last_d  = skid_last_q;

    // While the skid holds a beat, tready is low, so no new beat can arrive in the same cycle.
    if (skid_valid_q) begin
      if (out_free) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_user_d   = skid_user_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = sw_data;
        out_keep_d  = sw_keep;
        out_user_d  = s_axis.tuser;
        out_last_d  = s_axis.tlast;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = sw_data;
        skid_keep_d  = sw_keep;
        skid_user_d  = s_axis.tuser;
        skid_last_d  = s_axis.tlast;
      end
    end else if (out_valid_q & m_axis.tready) begin
      out_valid_d = 1'b0;
    end

    s_ready_d = ~skid_valid_d;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        mode_d  = CFG_SWAP_MODE;
        state_d = s_axis.tlast ? ST_IDLE : ST_IN_PKT;
      end else if (s_axis.tlast) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      mode_q       <= DEF_MODE;
      s_ready_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_user_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_user_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      s_ready_q    <= s_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_user_q   <= out_user_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_user_q  <= skid_user_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign s_axis.tready    = s_ready_q;
  assign m_axis.tvalid    = out_valid_q;
  assign m_axis.tdata     = out_data_q;
  assign m_axis.tkeep     = out_keep_q;
  assign m_axis.tuser     = out_user_q;
  assign m_axis.tlast     = out_last_q;
  assign STAT_MODE_ACTIVE = mode_q;
  assign DBG_FSM_STATE    = (state_q == ST_IN_PKT);

`ifdef OSNT_SWAPPER_STATS_EN
  logic [31:0] stat_pkt_q, stat_pkt_d;
  logic [31:0] stat_beat_q, stat_beat_d;
  logic        emit;

  // Clear wins over a same-cycle increment; both counters wrap naturally.
  always_comb begin
    emit        = out_valid_q & m_axis.tready;
    stat_pkt_d  = stat_pkt_q;
    stat_beat_d = stat_beat_q;
    if (STAT_CLR) begin
      stat_pkt_d  = '0;
      stat_beat_d = '0;
    end else if (emit) begin
      stat_beat_d = stat_beat_q + 32'd1;
      if (out_last_q) stat_pkt_d = stat_pkt_q + 32'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stat_pkt_q  <= '0;
      stat_beat_q <= '0;
    end else begin
      stat_pkt_q  <= stat_pkt_d;
      stat_beat_q <= stat_beat_d;
    end
  end

  assign STAT_PKT_CNT  = stat_pkt_q;
  assign STAT_BEAT_CNT = stat_beat_q;
`endif

endmodule

// File: tb/tb_osnt_sume_endianess_swapper.sv
// Self-checking bench for osnt_sume_endianess_swapper: vector table, hand-written corner sequences,
// randomized traffic against a byte-permutation reference model.
module tb_osnt_sume_endianess_swapper;
  localparam int W  = 256;
  localparam int NB = W / 8;
  localparam int U  = 128;
  localparam int EW = W + NB + U + 1;

  localparam logic [W-1:0] RAMP = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
  localparam logic [W-1:0] M1   = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [W-1:0] M2   = 256'h1C1D1E1F18191A1B14151617101112130C0D0E0F08090A0B0405060700010203;
  localparam logic [W-1:0] M3   = 256'h18191A1B1C1D1E1F101112131415161708090A0B0C0D0E0F0001020304050607;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic [1:0] mode_active;
  logic       dbg_state;
  always #5 clk = ~clk;

  osnt_sume_endianess_swapper_if #(.DATA_W(W), .USER_W(U)) s_if ();
  osnt_sume_endianess_swapper_if #(.DATA_W(W), .USER_W(U)) m_if ();

`ifdef OSNT_SWAPPER_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_pkt, stat_beat;
`endif

  osnt_sume_endianess_swapper #(
    .C_AXIS_TDATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(U), .C_DEFAULT_MODE(1)
  ) dut (
    .ACLK(clk), .ARESET(rst), .CFG_SWAP_MODE(cfg_mode),
    .s_axis(s_if), .m_axis(m_if),
    .STAT_MODE_ACTIVE(mode_active), .DBG_FSM_STATE(dbg_state)
`ifdef OSNT_SWAPPER_STATS_EN
    , .STAT_CLR(stat_clr), .STAT_PKT_CNT(stat_pkt), .STAT_BEAT_CNT(stat_beat)
`endif
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached", name);
  endfunction

  // Reference: output byte i takes input byte src(i) of the selected granularity.
  function automatic logic [EW-1:0] model_beat(input logic [1:0] mode, input logic [W-1:0] d,
                                               input logic [NB-1:0] k, input logic [U-1:0] u, input logic l);
    logic [W-1:0]  od;
    logic [NB-1:0] ok;
    int src;
    for (int i = 0; i < NB; i++) begin
      case (mode)
        2'd0:    src = i;
        2'd1:    src = NB - 1 - i;
        2'd2:    src = (i / 4) * 4 + 3 - (i % 4);
        default: src = (i / 8) * 8 + 7 - (i % 8);
      endcase
      od[8*i +: 8] = d[8*src +: 8];
      ok[i]        = k[src];
    end
    return {l, u, ok, od};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_cur, hold_val;
  logic          hold_pend = 1'b0;
  logic          ref_in_pkt = 1'b0;
  logic [1:0]    ref_mode = 2'd1;
  int cyc = 0, emit_cnt = 0, stall_cnt = 0, sready_low_cnt = 0, first_emit = 0, last_emit = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend  = 1'b0;
      ref_in_pkt = 1'b0;
      ref_mode   = 2'd1;
    end else begin
      mon_cur = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
      if (hold_pend) check("hold_stable", mon_cur, hold_val);
      hold_pend = m_if.tvalid && !m_if.tready;
      hold_val  = mon_cur;
      if (m_if.tvalid && !m_if.tready) stall_cnt++;
      if (s_if.tvalid && !s_if.tready) sready_low_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("beat", mon_cur, exp_q.pop_front());
        emit_cnt++;
        if (emit_cnt == 1) first_emit = cyc;
        last_emit = cyc;
      end
      if (s_if.tvalid && s_if.tready) begin
        if (!ref_in_pkt) ref_mode = cfg_mode;
        exp_q.push_back(model_beat(ref_mode, s_if.tdata, s_if.tkeep, s_if.tuser, s_if.tlast));
        ref_in_pkt = !s_if.tlast;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [U-1:0] rand_user();
    logic [U-1:0] u;
    for (int i = 0; i < U / 32; i++) u[32*i +: 32] = $urandom;
    return u;
  endfunction

  task automatic send_beat(input logic [W-1:0] d, input logic [NB-1:0] k, input logic [U-1:0] u, input logic l);
    int  n;
    bit  hs;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    n = 0;
    do begin
      hs = s_if.tready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) fail_now("send_timeout");
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    mode;
    logic [NB-1:0] keep;
    logic [W-1:0]  exp_data;
    logic [NB-1:0] exp_keep;
  } vec_t;
  vec_t vecs[8];

  bit rnd_done;

  initial begin
    vecs[0] = '{2'd1, 32'h0000FFFF, M1,   32'hFFFF0000};
    vecs[1] = '{2'd2, 32'h0000FFFF, M2,   32'h0000FFFF};
    vecs[2] = '{2'd3, 32'h0000FFFF, M3,   32'h0000FFFF};
    vecs[3] = '{2'd0, 32'h0000FFFF, RAMP, 32'h0000FFFF};
    vecs[4] = '{2'd1, 32'h00000001, M1,   32'h80000000};
    vecs[5] = '{2'd2, 32'h00000001, M2,   32'h00000008};
    vecs[6] = '{2'd3, 32'h00000001, M3,   32'h00000080};
    vecs[7] = '{2'd1, 32'h00000000, M1,   32'h00000000};

    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tkeep", m_if.tkeep, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_mode_active", mode_active, 1);
    rst = 1'b0;
    #1;
    check("rel_s_tready_low", s_if.tready, 0);
    @(posedge clk); #1;
    check("rel_s_tready_high", s_if.tready, 1);

    // Single-beat vectors: latency and swap per mode
    for (int v = 0; v < 8; v++) begin
      cfg_mode = vecs[v].mode;
      send_beat(RAMP, vecs[v].keep, rand_user(), 1'b1);
      check($sformatf("vec%0d_valid", v), m_if.tvalid, 1);
      check($sformatf("vec%0d_data", v), m_if.tdata, vecs[v].exp_data);
      check($sformatf("vec%0d_keep", v), m_if.tkeep, vecs[v].exp_keep);
      check($sformatf("vec%0d_last", v), m_if.tlast, 1);
      check($sformatf("vec%0d_mode", v), mode_active, vecs[v].mode);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid_drop", v), m_if.tvalid, 0);
    end

    // Mode change mid-packet is ignored until the next first beat
    cfg_mode = 2'd1;
    send_beat(rand_data(), 32'hFFFFFFFF, rand_user(), 1'b0);
    check("pkt4_state_in", dbg_state, 1);
    cfg_mode = 2'd2;
    for (int b = 1; b < 4; b++) send_beat(RAMP, 32'hFFFFFFFF, rand_user(), b == 3);
    check("pkt4_last_data", m_if.tdata, M1);
    check("pkt4_state_idle", dbg_state, 0);
    check("pkt4_mode", mode_active, 1);
    send_beat(RAMP, 32'hFFFFFFFF, rand_user(), 1'b1);
    check("next_pkt_data", m_if.tdata, M2);
    check("next_pkt_mode", mode_active, 2);
    drain();

    // Continuous 64-beat stream with a 3-cycle output stall at beat 10
    emit_cnt = 0; stall_cnt = 0; sready_low_cnt = 0;
    fork
      begin
        for (int b = 0; b < 64; b++) send_beat(rand_data(), $urandom, rand_user(), b == 63);
      end
      begin
        int n;
        n = 0;
        while (emit_cnt < 10 && n < 500) begin @(posedge clk); #1; n++; end
        if (emit_cnt < 10) fail_now("stream_wait");
        m_if.tready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        m_if.tready = 1'b1;
      end
    join
    drain();
    check("stream_count", emit_cnt, 64);
    check("stream_stalls", stall_cnt, 3);
    check("stream_sready_low", sready_low_cnt, 3);
    check("stream_span", last_emit - first_emit, 66);

    // Reset pulse during beat 2 of a 5-beat packet
    cfg_mode = 2'd3;
    send_beat(rand_data(), 32'hFFFFFFFF, rand_user(), 1'b0);
    send_beat(rand_data(), 32'hFFFFFFFF, rand_user(), 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_if.tvalid, 0);
    check("mid_rst_m_tdata", m_if.tdata, 0);
    check("mid_rst_s_tready", s_if.tready, 0);
    check("mid_rst_mode", mode_active, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_s_tready_low", s_if.tready, 0);
    @(posedge clk); #1;
    check("post_rst_s_tready_high", s_if.tready, 1);
    check("post_rst_state", dbg_state, 0);
    cfg_mode = 2'd2;
    send_beat(RAMP, 32'hFFFFFFFF, rand_user(), 1'b1);
    check("post_rst_data", m_if.tdata, M2);
    check("post_rst_mode", mode_active, 2);
    drain();

    // Randomized packets, idle gaps, mid-packet config churn and output backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 8);
          cfg_mode = 2'($urandom_range(0, 3));
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            if ($urandom_range(0, 4) == 0) cfg_mode = 2'($urandom_range(0, 3));
            send_beat(rand_data(), $urandom, rand_user(), b == len - 1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_if.tready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        m_if.tready = 1'b1;
      end
    join
    drain();

`ifdef OSNT_SWAPPER_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr_pkt0", stat_pkt, 0);
    check("stat_clr_beat0", stat_beat, 0);
    send_beat(rand_data(), $urandom, rand_user(), 1'b1);
    for (int b = 0; b < 2; b++) send_beat(rand_data(), $urandom, rand_user(), b == 1);
    for (int b = 0; b < 5; b++) send_beat(rand_data(), $urandom, rand_user(), b == 4);
    drain();
    @(posedge clk); #1;
    check("stat_pkt", stat_pkt, 3);
    check("stat_beat", stat_beat, 8);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr_pkt", stat_pkt, 0);
    check("stat_clr_beat", stat_beat, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
